ahbl_master_arbiter: RTL and testbench
======================================

Name: ahbl_master_arbiter

Overview:
Two-master AHB-Lite arbiter sharing one downstream AHB-Lite port between the CPU (M0) and the DMA controller master port (M1).
AHB-Lite masters have no request/grant wires, so a master that loses arbitration has its address phase captured in a holding register and is stalled through its own HREADY.
The block sits between the CPU/DMAC master ports and the system bus decoder/splitter.
Only SINGLE transfers are supported: HTRANS IDLE or NONSEQ; SEQ is treated as NONSEQ, there is no HBURST, and there is no error response.

Parameters:
PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with M0 highest.
ADDR_W, 32, address width.

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
M0_HADDR / M1_HADDR  in  ADDR_W  master address
M0_HTRANS / M1_HTRANS  in  2  master transfer type
M0_HSIZE / M1_HSIZE  in  3  master transfer size
M0_HWRITE / M1_HWRITE  in  1  master write flag
M0_HWDATA / M1_HWDATA  in  32  master write data
M0_HRDATA / M1_HRDATA  out  32  read data (copy of S_HRDATA)
M0_HREADY / M1_HREADY  out  1  per-master ready/stall
S_HADDR  out  ADDR_W  downstream address
S_HTRANS  out  2  downstream transfer type
S_HSIZE  out  3  downstream transfer size
S_HWRITE  out  1  downstream write flag
S_HWDATA  out  32  downstream write data
S_HRDATA  in  32  downstream read data
S_HREADY  in  1  downstream ready
GNT  out  2  one-hot current address-phase owner; 00 when idle

Behaviour:
- Reset values:
  - pending flags clear; data-phase valid clear; last_grant = M1, so M0 wins the first conflict.
  - Mi_HREADY = 1; S_HTRANS = IDLE; S_HADDR = 0; S_HSIZE = 0; S_HWRITE = 0; GNT = 00.
- New request for master i: Mi_HTRANS[1] & Mi_HREADY in the same cycle.
  - req_i = pend_vld_i | new request.
  - Request attributes come from the pending register when pend_vld_i is set, otherwise from the live inputs.
- Arbitration is evaluated every cycle but takes effect only when S_HREADY = 1.
  - One requester: it is granted.
  - Both requesting, PRIO_MODE = 0: grant the master that is not last_grant.
  - Both requesting, PRIO_MODE = 1: grant M0.
  - last_grant updates on every issued transfer.
- Issue is combinational, with zero added latency for the winner.
  - S_HTRANS = NONSEQ; S_HADDR/S_HSIZE/S_HWRITE = the winner's attributes.
  - GNT = one-hot of the winner.
  - If no requester or S_HREADY = 0: S_HTRANS = IDLE and S_HADDR holds the last value.
- Capture: a new request that is not issued this cycle (lost arbitration, or S_HREADY = 0) is latched into pend_* and pend_vld_i is set at the next edge.
- pend_vld_i clears on the edge at which the pending request is issued.
- Data-phase tracking, on every edge with S_HREADY = 1:
  - dph_vld <= issued this cycle; dph_own <= winner.
  - While S_HREADY = 0 both are held.
- Mi_HREADY:
  - 0 if pend_vld_i;
  - else S_HREADY if dph_vld & dph_own == i;
  - else 1.
- S_HWDATA = HWDATA of dph_own, or 0 if !dph_vld.
- S_HRDATA is broadcast to both Mi_HRDATA; it is valid for the owner when its HREADY = 1.
- Pipelining: the owner may present its next address while its data phase completes with S_HREADY = 1. That request is arbitrated normally.
- Fairness: in round-robin mode a pending master is issued within 2 downstream address slots.
- Reset mid-transfer: pending requests are dropped and all outputs return to reset values asynchronously. Masters are reset by the same HRESETn.

Decomposition:
- Shared header ahbl_util.vh gets: HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, and the M0/M1 index constants.
- One sub-module, ahbl_arb_input_stage, instantiated twice. It contains:
  - the pending register (addr, size, write, vld);
  - the request decode;
  - the attribute mux.

Test Plan:
- M1 alone writes 0x4000_0010 with data 0xA5A5_5A5A, S_HREADY = 1 -> S_HTRANS = 2 in the same cycle, S_HWDATA = 0xA5A5_5A5A next cycle, M1_HREADY never 0, GNT = 10.
- PRIO_MODE = 0, M0 reads 0x2000_0000 and M1 reads 0x3000_0004 in the same cycle t ->
  - M0 issued at t;
  - M1 issued at t+1 from the pending register;
  - M1_HREADY = 0 at t+1, = 1 at t+2 with S_HRDATA.
- PRIO_MODE = 1, M0 issues back-to-back reads for 6 cycles while M1 requests at cycle 0 -> M1 is stalled and issued only after M0 goes IDLE. The same stimulus with PRIO_MODE = 0 -> issues alternate M0, M1, M0...
- M0 data phase with S_HREADY = 0 for 3 cycles, M1 requests during the stall ->
  - M1 is captured; M0_HREADY follows S_HREADY;
  - M1 is issued on the first S_HREADY = 1 edge;
  - M1's write data reaches S_HWDATA the next cycle.
- HRESETn asserted while M1 is pending and M0 is in a data phase -> pend_vld = 0, S_HTRANS = IDLE, both HREADY = 1, GNT = 00 immediately.
- DMAC copies 16 words from 0x2000_0000 to 0x2000_1000 while the CPU performs random reads, with a random-wait memory model -> destination matches source, and every CPU read returns the model value.

Source files
------------

// File: rtl/ahbl_master_arbiter_pkg.sv
// Shared constants and arbitration helpers for the two-master AHB-Lite arbiter.
package ahbl_master_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // On a conflict, round-robin hands the slot to whichever master did not win last.
    function automatic logic pick_winner(input logic req0, input logic req1,
                                         input logic last_grant, input logic fixed_prio);
        if (req0 && req1) begin
            return fixed_prio ? M0 : ~last_grant;
        end
        return req0 ? M0 : M1;
    endfunction

    function automatic logic [1:0] grant_onehot(input logic id);
        return (id == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ahbl_arb_input_stage.sv
// Per-master front end: detects a new address phase, parks it when it loses
// arbitration, and presents either the parked or the live attributes.
module ahbl_arb_input_stage
    import ahbl_master_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic [2:0]        hsize,
    input  logic              hwrite,
    input  logic              hready,
    input  logic              issue,
    output logic              req,
    output logic [ADDR_W-1:0] req_addr,
    output logic [2:0]        req_size,
    output logic              req_write,
    output logic              pend_vld
);

    logic              new_req;
    logic [ADDR_W-1:0] pend_addr;
    logic [2:0]        pend_size;
    logic              pend_write;
    logic              unused_htrans0;

    // SEQ is handled exactly like NONSEQ, so only bit 1 of HTRANS matters.
    assign unused_htrans0 = htrans[0];
    assign new_req        = htrans[1] & hready;
    assign req            = pend_vld | new_req;

    assign req_addr  = pend_vld ? pend_addr  : haddr;
    assign req_size  = pend_vld ? pend_size  : hsize;
    assign req_write = pend_vld ? pend_write : hwrite;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_size  <= '0;
            pend_write <= 1'b0;
        end else if (pend_vld && issue) begin
            pend_vld <= 1'b0;
        end else if (new_req && !issue) begin
            pend_vld   <= 1'b1;
            pend_addr  <= haddr;
            pend_size  <= hsize;
            pend_write <= hwrite;
        end
    end

endmodule

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter: CPU (M0) and DMAC (M1) share one downstream port;
// the loser is parked in its input stage and stalled through its own HREADY.
module ahbl_master_arbiter
    import ahbl_master_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int ADDR_W    = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [ADDR_W-1:0] M0_HADDR,
    input  logic [1:0]        M0_HTRANS,
    input  logic [2:0]        M0_HSIZE,
    input  logic              M0_HWRITE,
    input  logic [31:0]       M0_HWDATA,
    output logic [31:0]       M0_HRDATA,
    output logic              M0_HREADY,
    input  logic [ADDR_W-1:0] M1_HADDR,
    input  logic [1:0]        M1_HTRANS,
    input  logic [2:0]        M1_HSIZE,
    input  logic              M1_HWRITE,
    input  logic [31:0]       M1_HWDATA,
    output logic [31:0]       M1_HRDATA,
    output logic              M1_HREADY,
    output logic [ADDR_W-1:0] S_HADDR,
    output logic [1:0]        S_HTRANS,
    output logic [2:0]        S_HSIZE,
    output logic              S_HWRITE,
    output logic [31:0]       S_HWDATA,
    input  logic [31:0]       S_HRDATA,
    input  logic              S_HREADY,
    output logic [1:0]        GNT
);

    localparam logic FIXED_PRIO = (PRIO_MODE != 0);

    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [2:0]        m0_size, m1_size;
    logic              m0_write, m1_write;
    logic              m0_pend, m1_pend;

    logic              winner;
    logic              issue;
    logic [ADDR_W-1:0] win_addr;
    logic [2:0]        win_size;
    logic              win_write;

    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        size_q;
    logic              write_q;
    logic              dph_vld;
    logic              dph_own;

    ahbl_arb_input_stage #(.ADDR_W(ADDR_W)) u_stage_m0 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .haddr     (M0_HADDR),
        .htrans    (M0_HTRANS),
        .hsize     (M0_HSIZE),
        .hwrite    (M0_HWRITE),
        .hready    (M0_HREADY),
        .issue     (issue && (winner == M0)),
        .req       (m0_req),
        .req_addr  (m0_addr),
        .req_size  (m0_size),
        .req_write (m0_write),
        .pend_vld  (m0_pend)
    );

    ahbl_arb_input_stage #(.ADDR_W(ADDR_W)) u_stage_m1 (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .haddr     (M1_HADDR),
        .htrans    (M1_HTRANS),
        .hsize     (M1_HSIZE),
        .hwrite    (M1_HWRITE),
        .hready    (M1_HREADY),
        .issue     (issue && (winner == M1)),
        .req       (m1_req),
        .req_addr  (m1_addr),
        .req_size  (m1_size),
        .req_write (m1_write),
        .pend_vld  (m1_pend)
    );

    assign winner    = pick_winner(m0_req, m1_req, last_grant, FIXED_PRIO);
    assign issue     = (m0_req | m1_req) & S_HREADY;
    assign win_addr  = (winner == M1) ? m1_addr  : m0_addr;
    assign win_size  = (winner == M1) ? m1_size  : m0_size;
    assign win_write = (winner == M1) ? m1_write : m0_write;

    // The winner goes straight onto the bus; otherwise the last address is held.
    assign S_HTRANS = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign S_HADDR  = issue ? win_addr  : addr_q;
    assign S_HSIZE  = issue ? win_size  : size_q;
    assign S_HWRITE = issue ? win_write : write_q;
    assign GNT      = issue ? grant_onehot(winner) : 2'b00;

    assign S_HWDATA  = !dph_vld ? 32'd0 : ((dph_own == M1) ? M1_HWDATA : M0_HWDATA);
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

    // A parked master is always stalled; the data-phase owner sees the slave's ready.
    assign M0_HREADY = m0_pend ? 1'b0 : ((dph_vld && dph_own == M0) ? S_HREADY : 1'b1);
    assign M1_HREADY = m1_pend ? 1'b0 : ((dph_vld && dph_own == M1) ? S_HREADY : 1'b1);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_grant <= M1;
            addr_q     <= '0;
            size_q     <= '0;
            write_q    <= 1'b0;
            dph_vld    <= 1'b0;
            dph_own    <= M0;
        end else begin
            if (issue) begin
                last_grant <= winner;
                addr_q     <= win_addr;
                size_q     <= win_size;
                write_q    <= win_write;
            end
            if (S_HREADY) begin
                dph_vld <= issue;
                dph_own <= winner;
            end
        end
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Bench for ahbl_master_arbiter: a round-robin and a fixed-priority instance share
// the same stimulus and are each checked every cycle against a transaction-level model.
module tb_ahbl_master_arbiter;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hwrite, m1_hwrite;
    logic [31:0] s_hrdata;
    logic        s_hready;

    logic [31:0] r_m0_hrdata, r_m1_hrdata, r_s_haddr, r_s_hwdata;
    logic        r_m0_hready, r_m1_hready, r_s_hwrite;
    logic [1:0]  r_s_htrans, r_gnt;
    logic [2:0]  r_s_hsize;
    logic [31:0] p_m0_hrdata, p_m1_hrdata, p_s_haddr, p_s_hwdata;
    logic        p_m0_hready, p_m1_hready, p_s_hwrite;
    logic [1:0]  p_s_htrans, p_gnt;
    logic [2:0]  p_s_hsize;

    int nvec = 0;
    int nerr = 0;

    ahbl_master_arbiter #(.PRIO_MODE(0), .ADDR_W(32)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize), .M0_HWRITE(m0_hwrite),
        .M0_HWDATA(m0_hwdata), .M0_HRDATA(r_m0_hrdata), .M0_HREADY(r_m0_hready),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize), .M1_HWRITE(m1_hwrite),
        .M1_HWDATA(m1_hwdata), .M1_HRDATA(r_m1_hrdata), .M1_HREADY(r_m1_hready),
        .S_HADDR(r_s_haddr), .S_HTRANS(r_s_htrans), .S_HSIZE(r_s_hsize), .S_HWRITE(r_s_hwrite),
        .S_HWDATA(r_s_hwdata), .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .GNT(r_gnt)
    );

    ahbl_master_arbiter #(.PRIO_MODE(1), .ADDR_W(32)) dut_prio (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HSIZE(m0_hsize), .M0_HWRITE(m0_hwrite),
        .M0_HWDATA(m0_hwdata), .M0_HRDATA(p_m0_hrdata), .M0_HREADY(p_m0_hready),
        .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HSIZE(m1_hsize), .M1_HWRITE(m1_hwrite),
        .M1_HWDATA(m1_hwdata), .M1_HRDATA(p_m1_hrdata), .M1_HREADY(p_m1_hready),
        .S_HADDR(p_s_haddr), .S_HTRANS(p_s_htrans), .S_HSIZE(p_s_hsize), .S_HWRITE(p_s_hwrite),
        .S_HWDATA(p_s_hwdata), .S_HRDATA(s_hrdata), .S_HREADY(s_hready), .GNT(p_gnt)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Model state: one parked request slot per master, who won last, who owns the data phase.
    typedef struct {
        bit          pv [2];
        logic [31:0] pa [2];
        logic [2:0]  ps [2];
        bit          pw [2];
        int          last;
        bit          dv;
        int          own;
        logic [31:0] ha;
        logic [2:0]  hs;
        bit          hw;
    } model_t;

    typedef struct {
        logic [1:0]  htrans;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
        logic [31:0] hwdata;
        logic [1:0]  gnt;
        logic        hready [2];
        logic [31:0] hrdata [2];
    } obs_t;

    model_t cur [2];
    model_t nxt [2];

    task automatic model_reset(input int d);
        for (int i = 0; i < 2; i++) begin
            cur[d].pv[i] = 0; cur[d].pa[i] = 0; cur[d].ps[i] = 0; cur[d].pw[i] = 0;
        end
        cur[d].last = 1; cur[d].dv = 0; cur[d].own = 0;
        cur[d].ha = 0; cur[d].hs = 0; cur[d].hw = 0;
        nxt[d] = cur[d];
    endtask

    task automatic model_eval(input int d, output obs_t e);
        logic [1:0]  t [2];
        logic [31:0] a [2];
        logic [2:0]  s [2];
        bit          w [2];
        bit          fresh [2];
        int          cand [$];
        int          win;
        bit          go;
        t[0] = m0_htrans; a[0] = m0_haddr; s[0] = m0_hsize; w[0] = m0_hwrite;
        t[1] = m1_htrans; a[1] = m1_haddr; s[1] = m1_hsize; w[1] = m1_hwrite;
        nxt[d] = cur[d];
        e.hrdata[0] = s_hrdata;
        e.hrdata[1] = s_hrdata;
        if (!HRESETn) begin
            e.htrans = 0; e.haddr = 0; e.hsize = 0; e.hwrite = 0; e.hwdata = 0; e.gnt = 0;
            e.hready[0] = 1; e.hready[1] = 1;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (cur[d].pv[i])                     e.hready[i] = 0;
            else if (cur[d].dv && cur[d].own == i) e.hready[i] = s_hready;
            else                                  e.hready[i] = 1;
            fresh[i] = t[i][1] && e.hready[i];
            if (cur[d].pv[i] || fresh[i]) cand.push_back(i);
        end
        win = 0;
        if (cand.size() == 2) win = (d == 1) ? 0 : 1 - cur[d].last;
        else if (cand.size() == 1) win = cand[0];
        go = (cand.size() > 0) && s_hready;
        if (cur[d].pv[win]) begin
            a[win] = cur[d].pa[win]; s[win] = cur[d].ps[win]; w[win] = cur[d].pw[win];
        end
        e.htrans = go ? 2'b10 : 2'b00;
        e.haddr  = go ? a[win] : cur[d].ha;
        e.hsize  = go ? s[win] : cur[d].hs;
        e.hwrite = go ? w[win] : cur[d].hw;
        e.gnt    = go ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
        e.hwdata = !cur[d].dv ? 32'd0 : ((cur[d].own == 1) ? m1_hwdata : m0_hwdata);
        for (int i = 0; i < 2; i++) begin
            if (go && win == i) nxt[d].pv[i] = 0;
            else if (fresh[i]) begin
                nxt[d].pv[i] = 1;
                nxt[d].pa[i] = (i == 1) ? m1_haddr : m0_haddr;
                nxt[d].ps[i] = (i == 1) ? m1_hsize : m0_hsize;
                nxt[d].pw[i] = (i == 1) ? m1_hwrite : m0_hwrite;
            end
        end
        if (go) begin
            nxt[d].last = win; nxt[d].ha = a[win]; nxt[d].hs = s[win]; nxt[d].hw = w[win];
        end
        if (s_hready) begin
            nxt[d].dv = go;
            if (go) nxt[d].own = win;
        end
    endtask

    task automatic get_obs(input int d, output obs_t o);
        if (d == 0) begin
            o.htrans = r_s_htrans; o.haddr = r_s_haddr; o.hsize = r_s_hsize; o.hwrite = r_s_hwrite;
            o.hwdata = r_s_hwdata; o.gnt = r_gnt; o.hready[0] = r_m0_hready; o.hready[1] = r_m1_hready;
            o.hrdata[0] = r_m0_hrdata; o.hrdata[1] = r_m1_hrdata;
        end else begin
            o.htrans = p_s_htrans; o.haddr = p_s_haddr; o.hsize = p_s_hsize; o.hwrite = p_s_hwrite;
            o.hwdata = p_s_hwdata; o.gnt = p_gnt; o.hready[0] = p_m0_hready; o.hready[1] = p_m1_hready;
            o.hrdata[0] = p_m0_hrdata; o.hrdata[1] = p_m1_hrdata;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Mid-cycle compare of both instances against the model.
    task automatic settle();
        obs_t  e, o;
        string n;
        @(negedge HCLK);
        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? "rr" : "prio";
            model_eval(d, e);
            get_obs(d, o);
            checkOutput({n, ".S_HTRANS"}, 32'(o.htrans), 32'(e.htrans));
            checkOutput({n, ".S_HADDR"},  o.haddr,  e.haddr);
            checkOutput({n, ".S_HSIZE"},  32'(o.hsize),  32'(e.hsize));
            checkOutput({n, ".S_HWRITE"}, 32'(o.hwrite), 32'(e.hwrite));
            checkOutput({n, ".S_HWDATA"}, o.hwdata, e.hwdata);
            checkOutput({n, ".GNT"},      32'(o.gnt),    32'(e.gnt));
            checkOutput({n, ".M0_HREADY"}, 32'(o.hready[0]), 32'(e.hready[0]));
            checkOutput({n, ".M1_HREADY"}, 32'(o.hready[1]), 32'(e.hready[1]));
            checkOutput({n, ".M0_HRDATA"}, o.hrdata[0], e.hrdata[0]);
            checkOutput({n, ".M1_HRDATA"}, o.hrdata[1], e.hrdata[1]);
        end
    endtask

    task automatic advance();
        @(posedge HCLK);
        for (int d = 0; d < 2; d++) begin
            if (HRESETn) cur[d] = nxt[d];
            else model_reset(d);
        end
        #1;
    endtask

    task automatic applyStimulus(input int i, input logic [1:0] tr, input logic [31:0] addr,
                                 input logic wr, input logic [31:0] wdata);
        if (i == 0) begin
            m0_htrans = tr; m0_haddr = addr; m0_hwrite = wr; m0_hwdata = wdata; m0_hsize = 3'd2;
        end else begin
            m1_htrans = tr; m1_haddr = addr; m1_hwrite = wr; m1_hwdata = wdata; m1_hsize = 3'd2;
        end
    endtask

    task automatic idle_both();
        applyStimulus(0, 2'b00, 32'h0, 1'b0, 32'h0);
        applyStimulus(1, 2'b00, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] src_pat(input int k);
        return 32'hC0DE_0000 + 32'(k) * 32'h111;
    endfunction

    logic [31:0] mem [2048];
    logic [1:0]  rr_gnt_seq [7];
    logic [1:0]  pr_gnt_seq [7];

    initial begin
        bit          s_dv, s_wr, cpu_done, dma_done;
        int          s_wait, s_idx, c_phase, c_idx, cpu_cnt, d_phase, d_k;
        bit          d_write;
        logic [31:0] d_val;
        int          cyc;

        HRESETn = 1'b0; s_hready = 1'b1; s_hrdata = 32'h0;
        idle_both();
        model_reset(0); model_reset(1);

        // Reset values
        settle();
        checkOutput("reset.S_HTRANS", 32'(r_s_htrans), 32'h0);
        checkOutput("reset.GNT", 32'(r_gnt), 32'h0);
        checkOutput("reset.M0_HREADY", 32'(r_m0_hready), 32'h1);
        checkOutput("reset.S_HADDR", r_s_haddr, 32'h0);
        advance();
        settle();
        advance();
        HRESETn = 1'b1;

        // M1 alone writes
        applyStimulus(1, 2'b10, 32'h4000_0010, 1'b1, 32'h0);
        settle();
        checkOutput("m1wr.S_HTRANS", 32'(r_s_htrans), 32'h2);
        checkOutput("m1wr.GNT", 32'(r_gnt), 32'h2);
        checkOutput("m1wr.S_HADDR", r_s_haddr, 32'h4000_0010);
        checkOutput("m1wr.M1_HREADY.a", 32'(r_m1_hready), 32'h1);
        advance();
        applyStimulus(1, 2'b00, 32'h0, 1'b0, 32'hA5A5_5A5A);
        settle();
        checkOutput("m1wr.S_HWDATA", r_s_hwdata, 32'hA5A5_5A5A);
        checkOutput("m1wr.M1_HREADY.d", 32'(r_m1_hready), 32'h1);
        checkOutput("m1wr.S_HADDR.hold", r_s_haddr, 32'h4000_0010);
        advance();
        idle_both();
        settle(); advance();

        // Simultaneous reads: M0 wins the first conflict, M1 follows from its parked slot
        applyStimulus(0, 2'b10, 32'h2000_0000, 1'b0, 32'h0);
        applyStimulus(1, 2'b10, 32'h3000_0004, 1'b0, 32'h0);
        settle();
        checkOutput("conf.t.GNT", 32'(r_gnt), 32'h1);
        checkOutput("conf.t.S_HADDR", r_s_haddr, 32'h2000_0000);
        checkOutput("conf.t.prio.GNT", 32'(p_gnt), 32'h1);
        advance();
        idle_both();
        s_hrdata = 32'h1111_1111;
        settle();
        checkOutput("conf.t1.GNT", 32'(r_gnt), 32'h2);
        checkOutput("conf.t1.S_HADDR", r_s_haddr, 32'h3000_0004);
        checkOutput("conf.t1.M1_HREADY", 32'(r_m1_hready), 32'h0);
        checkOutput("conf.t1.M0_HRDATA", r_m0_hrdata, 32'h1111_1111);
        advance();
        s_hrdata = 32'h2222_2222;
        settle();
        checkOutput("conf.t2.M1_HREADY", 32'(r_m1_hready), 32'h1);
        checkOutput("conf.t2.M1_HRDATA", r_m1_hrdata, 32'h2222_2222);
        advance();
        s_hrdata = 32'h0;
        settle(); advance();

        // M0 streams for 6 cycles while M1 asks once at cycle 0
        rr_gnt_seq = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        pr_gnt_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int c = 0; c < 7; c++) begin
            if (c < 6) applyStimulus(0, 2'b10, 32'h0000_0100 + 32'(4 * c), 1'b0, 32'h0);
            else       applyStimulus(0, 2'b00, 32'h0, 1'b0, 32'h0);
            if (c == 0) applyStimulus(1, 2'b10, 32'h0000_0500, 1'b0, 32'h0);
            else        applyStimulus(1, 2'b00, 32'h0, 1'b0, 32'h0);
            settle();
            checkOutput($sformatf("stream.rr.GNT.c%0d", c), 32'(r_gnt), 32'(rr_gnt_seq[c]));
            checkOutput($sformatf("stream.prio.GNT.c%0d", c), 32'(p_gnt), 32'(pr_gnt_seq[c]));
            if (c == 2) checkOutput("stream.rr.S_HADDR.c2", r_s_haddr, 32'h0000_0104);
            if (c == 6) checkOutput("stream.prio.S_HADDR.c6", p_s_haddr, 32'h0000_0500);
            advance();
        end
        idle_both();
        settle(); advance();
        settle(); advance();

        // Downstream wait states on an M0 read while M1 requests
        applyStimulus(0, 2'b10, 32'h0000_0600, 1'b0, 32'h0);
        settle(); advance();
        for (int c = 1; c < 4; c++) begin
            s_hready = 1'b0;
            applyStimulus(0, 2'b00, 32'h0, 1'b0, 32'h0);
            if (c == 1) applyStimulus(1, 2'b10, 32'h0000_0700, 1'b1, 32'h0);
            else        applyStimulus(1, 2'b00, 32'h0, 1'b0, 32'hDEAD_BEEF);
            settle();
            checkOutput($sformatf("wait.M0_HREADY.c%0d", c), 32'(r_m0_hready), 32'h0);
            checkOutput($sformatf("wait.GNT.c%0d", c), 32'(r_gnt), 32'h0);
            if (c > 1) checkOutput($sformatf("wait.M1_HREADY.c%0d", c), 32'(r_m1_hready), 32'h0);
            advance();
        end
        s_hready = 1'b1;
        s_hrdata = 32'h600D_600D;
        settle();
        checkOutput("wait.c4.M0_HREADY", 32'(r_m0_hready), 32'h1);
        checkOutput("wait.c4.GNT", 32'(r_gnt), 32'h2);
        checkOutput("wait.c4.S_HADDR", r_s_haddr, 32'h0000_0700);
        checkOutput("wait.c4.S_HWRITE", 32'(r_s_hwrite), 32'h1);
        checkOutput("wait.c4.prio.GNT", 32'(p_gnt), 32'h2);
        advance();
        s_hrdata = 32'h0;
        settle();
        checkOutput("wait.c5.S_HWDATA", r_s_hwdata, 32'hDEAD_BEEF);
        checkOutput("wait.c5.M1_HREADY", 32'(r_m1_hready), 32'h1);
        advance();
        idle_both();
        settle(); advance();

        // Reset while M1 is parked and M0 is in its data phase
        applyStimulus(0, 2'b10, 32'h0000_0800, 1'b0, 32'h0);
        applyStimulus(1, 2'b10, 32'h0000_0900, 1'b0, 32'h0);
        settle(); advance();
        idle_both();
        s_hready = 1'b0;
        #1;
        checkOutput("rst.pre.M1_HREADY", 32'(r_m1_hready), 32'h0);
        HRESETn = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        checkOutput("rst.S_HTRANS", 32'(r_s_htrans), 32'h0);
        checkOutput("rst.GNT", 32'(r_gnt), 32'h0);
        checkOutput("rst.M0_HREADY", 32'(r_m0_hready), 32'h1);
        checkOutput("rst.M1_HREADY", 32'(r_m1_hready), 32'h1);
        checkOutput("rst.S_HADDR", r_s_haddr, 32'h0);
        checkOutput("rst.prio.M1_HREADY", 32'(p_m1_hready), 32'h1);
        settle(); advance();
        HRESETn = 1'b1;
        s_hready = 1'b1;
        settle(); advance();

        // DMAC copies 16 words while the CPU does random reads, against a wait-state memory
        for (int k = 0; k < 2048; k++) mem[k] = 32'h0;
        for (int k = 0; k < 16; k++) mem[k] = src_pat(k);
        s_dv = 0; s_wr = 0; s_wait = 0; s_idx = 0;
        c_phase = 0; c_idx = 3; cpu_cnt = 0; cpu_done = 0;
        d_phase = 0; d_k = 0; d_write = 0; d_val = 0; dma_done = 0;
        cyc = 0;
        while (!(cpu_done && dma_done) && cyc < 2000) begin
            s_hready = !s_dv || (s_wait == 0);
            s_hrdata = (s_dv && !s_wr) ? mem[s_idx] : 32'h0;
            applyStimulus(0, (c_phase == 0 && !cpu_done) ? 2'b10 : 2'b00,
                          32'h2000_0000 + 32'(4 * c_idx), 1'b0, 32'h0);
            applyStimulus(1, (d_phase == 0 && !dma_done) ? 2'b10 : 2'b00,
                          (d_write ? 32'h2000_1000 : 32'h2000_0000) + 32'(4 * d_k), d_write,
                          (d_phase == 1) ? d_val : 32'h0);
            settle();
            if (s_hready) begin
                if (s_dv && s_wr) mem[s_idx] = r_s_hwdata;
                s_dv = r_s_htrans[1];
                s_wr = r_s_hwrite;
                s_idx = int'(r_s_haddr[12:2]);
                s_wait = $urandom_range(0, 2);
            end else begin
                s_wait--;
            end
            if (!cpu_done && r_m0_hready) begin
                if (c_phase == 0) c_phase = 1;
                else begin
                    checkOutput($sformatf("cpu.rd%0d", cpu_cnt), r_m0_hrdata, src_pat(c_idx));
                    cpu_cnt++;
                    c_idx = $urandom_range(0, 15);
                    c_phase = 0;
                    if (cpu_cnt == 20) cpu_done = 1;
                end
            end
            if (!dma_done && r_m1_hready) begin
                if (d_phase == 0) d_phase = 1;
                else begin
                    if (!d_write) begin
                        d_val = r_m1_hrdata;
                        d_write = 1;
                    end else begin
                        d_write = 0;
                        d_k++;
                        if (d_k == 16) dma_done = 1;
                    end
                    d_phase = 0;
                end
            end
            advance();
            cyc++;
        end
        checkOutput("copy.finished", 32'(cpu_done && dma_done), 32'h1);
        // Let the last write data phase land in memory before comparing.
        idle_both();
        while (s_dv && cyc < 2010) begin
            s_hready = (s_wait == 0);
            settle();
            if (s_hready) begin
                if (s_wr) mem[s_idx] = r_s_hwdata;
                s_dv = 0;
            end else s_wait--;
            advance();
            cyc++;
        end
        for (int k = 0; k < 16; k++)
            checkOutput($sformatf("copy.dst%0d", k), mem[12'h400 + k], src_pat(k));

        $display("[TB] == %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
